spi_slave_rx: RTL and testbench



---
 rtl/spi_slave_pkg.sv | 15 +
 rtl/spi_sync_edge.sv | 60 ++++++
 rtl/spi_slave_rx.sv | 202 ++++++++++++++++++++
 tb/tb_spi_slave_rx.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_pkg.sv
// Purpose: shared types and constants for the SPI mode-0 slave receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_slave_pkg;

   typedef enum logic [1:0] {
      WAIT_HIGH = 2'd0,
      IDLE      = 2'd1,
      SHIFT     = 2'd2
   } state_t;

   localparam int SPI_BITS_PER_BYTE   = 8;
   localparam int SYNC_STAGES_DEFAULT = 2;

endpackage

// File: rtl/spi_sync_edge.sv
// Purpose: SYNC_STAGES flip-flop synchronizer, one history register, registered rise/fall strobes.
// Latency: a pin edge shows up on rise/fall (and on dout) SYNC_STAGES+1 cycles later.
// Backpressure: none; strobes are single-cycle and cannot be stalled.
//
// Ports:
//   clk, rst      : system clock, synchronous active-high reset
//   din           : asynchronous input pin
//   dout          : synchronized level, time-aligned with rise/fall
//   rise, fall    : one-cycle edge strobes (held 0 when EDGE_EN = 0)
module spi_sync_edge #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RST_VAL     = 1'b0,
   parameter bit   EDGE_EN     = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   sync_last;

   assign sync_last = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= {SYNC_STAGES{RST_VAL}};
         prev_q <= RST_VAL;
      end else begin
         sync_q <= (sync_q << 1) | SYNC_STAGES'(din);
         prev_q <= sync_last;
      end
   end

   // dout is the history register, so a level consumed together with a
   // rise/fall strobe was sampled in the same cycle the edge was seen.
   assign dout = prev_q;

   generate
      if (EDGE_EN) begin : g_edge
         always_ff @(posedge clk) begin
            if (rst) begin
               rise <= 1'b0;
               fall <= 1'b0;
            end else begin
               rise <= sync_last & ~prev_q;
               fall <= ~sync_last & prev_q;
            end
         end
      end else begin : g_no_edge
         assign rise = 1'b0;
         assign fall = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/spi_slave_rx.sv
// Purpose: SPI mode-0 slave: oversampled receive of MSB-first bytes grouped into CS_n-framed words, MISO return path.
// Latency: o_RX_DV 1 cycle after the detected 8th SCK rise (SYNC_STAGES+2 after the pin); MISO valid SYNC_STAGES+2 after SCK/CS_n fall.
// Backpressure: none; the master owns the pace, all strobes are single-cycle pulses.
//
// Ports:
//   i_Clk, i_Rst                  : system clock (CLOCK_50), synchronous active-high reset
//   i_SPI_Clk/MOSI/CS_n           : asynchronous SPI pins from the master
//   i_TX_Byte                     : byte returned on MISO, sampled at CS_n fall and at byte boundaries
//   o_SPI_MISO                    : serial out, 0 outside SHIFT
//   o_RX_DV / o_RX_Byte           : completed-byte strobe and held byte
//   o_Word_DV / o_Word            : completed-word strobe and held word (first byte in MSBs)
//   o_Frame_Err                   : strobe on a CS_n rise mid-byte or mid-word
//   o_Busy                        : high while in SHIFT
module spi_slave_rx
   import spi_slave_pkg::*;
#(
   parameter int BYTES_PER_FRAME = 2,
   parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT
) (
   input  logic                                     i_Clk,
   input  logic                                     i_Rst,
   input  logic                                     i_SPI_Clk,
   input  logic                                     i_SPI_MOSI,
   input  logic                                     i_SPI_CS_n,
   input  logic [SPI_BITS_PER_BYTE-1:0]             i_TX_Byte,
   output logic                                     o_SPI_MISO,
   output logic                                     o_RX_DV,
   output logic [SPI_BITS_PER_BYTE-1:0]             o_RX_Byte,
   output logic                                     o_Word_DV,
   output logic [SPI_BITS_PER_BYTE*BYTES_PER_FRAME-1:0] o_Word,
   output logic                                     o_Frame_Err,
   output logic                                     o_Busy
);

   localparam int WORD_W = SPI_BITS_PER_BYTE * BYTES_PER_FRAME;
   localparam int BCNT_W = (BYTES_PER_FRAME > 1) ? $clog2(BYTES_PER_FRAME) : 1;
   localparam int SETTLE = SYNC_STAGES + 1;
   localparam int SCNT_W = $clog2(SETTLE + 1);

   // ------------------------------------------------------------------
   // Input synchronizers
   // ------------------------------------------------------------------
   logic sck_rise, sck_fall, sck_level_unused;
   logic mosi_s, mosi_rise_unused, mosi_fall_unused;
   logic cs_s, cs_rise, cs_fall;

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0), .EDGE_EN(1'b1)) u_sync_sck (
      .clk  (i_Clk),
      .rst  (i_Rst),
      .din  (i_SPI_Clk),
      .dout (sck_level_unused),
      .rise (sck_rise),
      .fall (sck_fall)
   );

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0), .EDGE_EN(1'b0)) u_sync_mosi (
      .clk  (i_Clk),
      .rst  (i_Rst),
      .din  (i_SPI_MOSI),
      .dout (mosi_s),
      .rise (mosi_rise_unused),
      .fall (mosi_fall_unused)
   );

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1), .EDGE_EN(1'b1)) u_sync_cs (
      .clk  (i_Clk),
      .rst  (i_Rst),
      .din  (i_SPI_CS_n),
      .dout (cs_s),
      .rise (cs_rise),
      .fall (cs_fall)
   );

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------
   state_t state, state_nxt;

   logic [SCNT_W-1:0]            settle_cnt;
   logic                         settle_done;
   logic [2:0]                   bit_cnt;
   logic [BCNT_W-1:0]            byte_cnt;
   logic [SPI_BITS_PER_BYTE-1:0] rx_sr;
   logic [SPI_BITS_PER_BYTE-1:0] tx_sr;
   logic [WORD_W-1:0]            word_sr;
   logic [SPI_BITS_PER_BYTE-1:0] rx_byte_nxt;
   logic [WORD_W-1:0]            word_nxt;

   logic start_frame, end_frame, do_rise, do_fall;

   // The CS_n synchronizer resets to 1, so right after reset it reports
   // "high" even when the pin is low. Trust it only once the reset values
   // have been flushed, otherwise a frame in flight at reset release would
   // be picked up mid-byte.
   assign settle_done = (settle_cnt == SCNT_W'(SETTLE));

   always_ff @(posedge i_Clk) begin
      if (i_Rst) state <= WAIT_HIGH;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      start_frame = 1'b0;
      end_frame   = 1'b0;
      do_rise     = 1'b0;
      do_fall     = 1'b0;
      case (state)
         WAIT_HIGH: begin
            if (settle_done && cs_s) state_nxt = IDLE;
         end
         IDLE: begin
            if (cs_fall) begin
               start_frame = 1'b1;
               state_nxt   = SHIFT;
            end
         end
         SHIFT: begin
            // A CS_n rise masks any SCK edge detected in the same cycle.
            if (cs_rise) begin
               end_frame = 1'b1;
               state_nxt = IDLE;
            end else if (sck_rise) begin
               do_rise = 1'b1;
            end else if (sck_fall) begin
               do_fall = 1'b1;
            end
         end
         default: state_nxt = WAIT_HIGH;
      endcase
   end

   // ------------------------------------------------------------------
   // Datapath
   // ------------------------------------------------------------------
   assign rx_byte_nxt = {rx_sr[SPI_BITS_PER_BYTE-2:0], mosi_s};
   assign word_nxt    = WORD_W'({word_sr, rx_byte_nxt});

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         settle_cnt  <= '0;
         bit_cnt     <= '0;
         byte_cnt    <= '0;
         rx_sr       <= '0;
         tx_sr       <= '0;
         word_sr     <= '0;
         o_RX_DV     <= 1'b0;
         o_RX_Byte   <= '0;
         o_Word_DV   <= 1'b0;
         o_Word      <= '0;
         o_Frame_Err <= 1'b0;
      end else begin
         o_RX_DV     <= 1'b0;
         o_Word_DV   <= 1'b0;
         o_Frame_Err <= 1'b0;

         if (state == WAIT_HIGH && !settle_done) settle_cnt <= settle_cnt + 1'b1;

         if (start_frame) begin
            bit_cnt  <= '0;
            byte_cnt <= '0;
            rx_sr    <= '0;
            tx_sr    <= i_TX_Byte;
         end

         if (do_rise) begin
            rx_sr   <= rx_byte_nxt;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
               o_RX_Byte <= rx_byte_nxt;
               o_RX_DV   <= 1'b1;
               word_sr   <= word_nxt;
               if (byte_cnt == BCNT_W'(BYTES_PER_FRAME - 1)) begin
                  o_Word    <= word_nxt;
                  o_Word_DV <= 1'b1;
                  byte_cnt  <= '0;
               end else begin
                  byte_cnt <= byte_cnt + 1'b1;
               end
            end
         end

         // bit_cnt == 0 on a fall means a byte boundary was just crossed:
         // the next byte to return is fetched here, not shifted.
         if (do_fall) begin
            if (bit_cnt == 3'd0) tx_sr <= i_TX_Byte;
            else                 tx_sr <= {tx_sr[SPI_BITS_PER_BYTE-2:0], 1'b0};
         end

         if (end_frame) begin
            o_Frame_Err <= (bit_cnt != 3'd0) || (byte_cnt != '0);
            bit_cnt     <= '0;
            byte_cnt    <= '0;
            rx_sr       <= '0;
         end
      end
   end

   assign o_SPI_MISO = (state == SHIFT) ? tx_sr[SPI_BITS_PER_BYTE-1] : 1'b0;
   assign o_Busy     = (state == SHIFT);

endmodule

// File: tb/tb_spi_slave_rx.sv
// Purpose: directed self-checking bench for spi_slave_rx (default 2-byte frames, 2 sync stages).
// Latency: n/a.
// Backpressure: n/a.
module tb_spi_slave_rx;

   localparam int HP = 5;   // SCK half period in CLOCK_50 cycles

   logic        CLOCK_50;
   logic        rst;
   logic        spi_clk;
   logic        spi_mosi;
   logic        spi_cs_n;
   logic [7:0]  tx_byte;
   logic        spi_miso;
   logic        rx_dv;
   logic [7:0]  rx_byte;
   logic        word_dv;
   logic [15:0] word;
   logic        frame_err;
   logic        busy;

   spi_slave_rx #(.BYTES_PER_FRAME(2), .SYNC_STAGES(2)) dut (
      .i_Clk       (CLOCK_50),
      .i_Rst       (rst),
      .i_SPI_Clk   (spi_clk),
      .i_SPI_MOSI  (spi_mosi),
      .i_SPI_CS_n  (spi_cs_n),
      .i_TX_Byte   (tx_byte),
      .o_SPI_MISO  (spi_miso),
      .o_RX_DV     (rx_dv),
      .o_RX_Byte   (rx_byte),
      .o_Word_DV   (word_dv),
      .o_Word      (word),
      .o_Frame_Err (frame_err),
      .o_Busy      (busy)
   );

   initial CLOCK_50 = 1'b0;
   always #10 CLOCK_50 = ~CLOCK_50;

   // ------------------------------------------------------------------
   // Output monitor: logs every strobe, sampled on the falling edge.
   // ------------------------------------------------------------------
   int          cyc = 0;
   int          rx_cnt = 0, word_cnt = 0, err_cnt = 0;
   int          stretch_cnt = 0, misalign_cnt = 0;
   int          last_dv_cyc = 0;
   logic [7:0]  rx_log [64];
   logic [15:0] word_log [16];
   logic        rx_dv_d = 1'b0, word_dv_d = 1'b0, err_d = 1'b0;

   always @(posedge CLOCK_50) cyc++;

   always @(negedge CLOCK_50) begin
      if (rx_dv) begin
         if (rx_cnt < 64) rx_log[rx_cnt] = rx_byte;
         rx_cnt++;
         last_dv_cyc = cyc;
      end
      if (word_dv) begin
         if (word_cnt < 16) word_log[word_cnt] = word;
         word_cnt++;
         if (!rx_dv) misalign_cnt++;
      end
      if (frame_err) err_cnt++;
      if ((rx_dv && rx_dv_d) || (word_dv && word_dv_d) || (frame_err && err_d)) stretch_cnt++;
      rx_dv_d   = rx_dv;
      word_dv_d = word_dv;
      err_d     = frame_err;
   end

   // ------------------------------------------------------------------
   // Checking and SPI master tasks
   // ------------------------------------------------------------------
   int n_checks = 0;
   int n_errors = 0;
   int last_rise_cyc = 0;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      assert (observed === expected)
      else begin
         n_errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge CLOCK_50);
   endtask

   task automatic cs_low();
      spi_cs_n = 1'b0;
      wait_cyc(HP);
   endtask

   task automatic cs_high();
      wait_cyc(HP);
      spi_cs_n = 1'b1;
      wait_cyc(12);
   endtask

   // Mode 0: MOSI set while SCK low, MISO captured on the rising edge.
   // tx_next is presented right after the last rising edge of the transfer.
   task automatic spi_xfer(input logic [7:0] b, input int nbits,
                           input logic [7:0] tx_next, output logic [7:0] got);
      got = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         spi_mosi = b[7-i];
         wait_cyc(HP);
         spi_clk = 1'b1;
         got = {got[6:0], spi_miso};
         last_rise_cyc = cyc;
         if (i == nbits - 1) tx_byte = tx_next;
         wait_cyc(HP);
         spi_clk = 1'b0;
      end
   endtask

   // ------------------------------------------------------------------
   // Directed sequence
   // ------------------------------------------------------------------
   initial begin
      int rx0, w0, e0;
      logic [7:0] m0, m1;

      rst      = 1'b1;
      spi_clk  = 1'b0;
      spi_mosi = 1'b0;
      spi_cs_n = 1'b1;
      tx_byte  = 8'h00;
      wait_cyc(5);
      rst = 1'b0;
      wait_cyc(1);

      check("reset_rx_dv",     32'(rx_dv),     32'h0);
      check("reset_rx_byte",   32'(rx_byte),   32'h0);
      check("reset_word_dv",   32'(word_dv),   32'h0);
      check("reset_word",      32'(word),      32'h0);
      check("reset_frame_err", 32'(frame_err), 32'h0);
      check("reset_busy",      32'(busy),      32'h0);
      check("reset_miso",      32'(spi_miso),  32'h0);
      wait_cyc(10);

      // Frame A5 3C, slave returns 96 96.
      rx0 = rx_cnt; w0 = word_cnt; e0 = err_cnt;
      tx_byte = 8'h96;
      cs_low();
      check("busy_in_frame", 32'(busy), 32'h1);
      spi_xfer(8'hA5, 8, 8'h96, m0);
      spi_xfer(8'h3C, 8, 8'h96, m1);
      check("rx_dv_latency", 32'(last_dv_cyc - last_rise_cyc), 32'd4);
      cs_high();
      check("f1_rx_count",   32'(rx_cnt - rx0),   32'd2);
      check("f1_rx_byte0",   32'(rx_log[rx0]),    32'hA5);
      check("f1_rx_byte1",   32'(rx_log[rx0+1]),  32'h3C);
      check("f1_word_count", 32'(word_cnt - w0),  32'd1);
      check("f1_word",       32'(word_log[w0]),   32'hA53C);
      check("f1_no_err",     32'(err_cnt - e0),   32'd0);
      check("f1_miso0",      32'(m0),             32'h96);
      check("f1_miso1",      32'(m1),             32'h96);
      check("f1_miso_idle",  32'(spi_miso),       32'h0);
      check("f1_busy_idle",  32'(busy),           32'h0);

      // Partial byte: 5 bits of F0.
      rx0 = rx_cnt; w0 = word_cnt; e0 = err_cnt;
      cs_low();
      spi_xfer(8'hF0, 5, 8'h00, m0);
      cs_high();
      check("part_err",      32'(err_cnt - e0),  32'd1);
      check("part_no_rx",    32'(rx_cnt - rx0),  32'd0);
      check("part_no_word",  32'(word_cnt - w0), 32'd0);
      check("part_rx_held",  32'(rx_byte),       32'h3C);
      check("part_word_held",32'(word),          32'hA53C);

      // Three bytes in a two-byte frame.
      rx0 = rx_cnt; w0 = word_cnt; e0 = err_cnt;
      cs_low();
      spi_xfer(8'h12, 8, 8'h00, m0);
      spi_xfer(8'h34, 8, 8'h00, m0);
      check("long_word_mid", 32'(word_cnt - w0), 32'd1);
      spi_xfer(8'h56, 8, 8'h00, m0);
      check("long_no_err_yet", 32'(err_cnt - e0), 32'd0);
      cs_high();
      check("long_rx_count", 32'(rx_cnt - rx0),  32'd3);
      check("long_rx_byte2", 32'(rx_log[rx0+2]), 32'h56);
      check("long_word_cnt", 32'(word_cnt - w0), 32'd1);
      check("long_word",     32'(word_log[w0]),  32'h1234);
      check("long_err",      32'(err_cnt - e0),  32'd1);
      check("long_word_held",32'(word),          32'h1234);

      // Reset mid-byte with CS_n low; clocking continues afterwards.
      rx0 = rx_cnt; w0 = word_cnt; e0 = err_cnt;
      cs_low();
      spi_xfer(8'hC0, 4, 8'h00, m0);
      rst = 1'b1;
      wait_cyc(3);
      rst = 1'b0;
      spi_xfer(8'hFF, 8, 8'h00, m0);
      spi_xfer(8'h0F, 8, 8'h00, m0);
      check("rst_busy",      32'(busy),          32'h0);
      check("rst_word_clr",  32'(word),          32'h0);
      cs_high();
      check("rst_no_rx",     32'(rx_cnt - rx0),  32'd0);
      check("rst_no_word",   32'(word_cnt - w0), 32'd0);
      check("rst_no_err",    32'(err_cnt - e0),  32'd0);
      cs_low();
      spi_xfer(8'h55, 8, 8'h00, m0);
      spi_xfer(8'hAA, 8, 8'h00, m0);
      cs_high();
      check("post_rst_rx0",  32'(rx_log[rx0]),   32'h55);
      check("post_rst_rx1",  32'(rx_log[rx0+1]), 32'hAA);
      check("post_rst_word", 32'(word_log[w0]),  32'h55AA);
      check("post_rst_err",  32'(err_cnt - e0),  32'd0);

      // DAC-style word BEEF, return byte changes between bytes.
      rx0 = rx_cnt; w0 = word_cnt; e0 = err_cnt;
      tx_byte = 8'hC5;
      cs_low();
      spi_xfer(8'hBE, 8, 8'h7E, m0);
      spi_xfer(8'hEF, 8, 8'h00, m1);
      cs_high();
      check("dac_word",      32'(word),          32'hBEEF);
      check("dac_word_cnt",  32'(word_cnt - w0), 32'd1);
      check("dac_no_err",    32'(err_cnt - e0),  32'd0);
      check("dac_miso0",     32'(m0),            32'hC5);
      check("dac_miso1",     32'(m1),            32'h7E);

      check("no_stretch",    32'(stretch_cnt),   32'd0);
      check("word_dv_align", 32'(misalign_cnt),  32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
